// File: rtl/pu_or1k_ctrl_lsu_responder.sv
// pu_or1k_ctrl_lsu_responder
//   Control-stage load/store responder. Accepts one LSU op from the
//   execute->ctrl registers, runs a single data-bus access for it and returns
//   valid / load data / exceptions to the ctrl stage.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   padv_ctrl_i              ctrl stage advancing (retires a completed access)
//   pipeline_flush_i         flush (clears exceptions, aborts in-flight access)
//   ctrl_op_lsu_*_i          load / store / atomic qualifiers
//   ctrl_lsu_length_i        00 byte, 01 half, 10 word
//   ctrl_lsu_zext_i          zero-extend load result (else sign-extend)
//   ctrl_lsu_adr_i           effective address
//   ctrl_rfb_i               store data
//   lsu_result_o             aligned, extended load data
//   lsu_valid_o              access complete
//   lsu_except_dbus_o        bus error
//   lsu_except_align_o       misaligned access
//   atomic_flag_set_o/clear_o swa outcome pulses
//   msync_stall_o            bus access outstanding
//   dbus_*                   data-bus master port (big-endian lanes)
//
// Configuration
//   PU_OR1K_LSU_ATOMIC_EN    enables the lwa/swa reservation logic; without
//                            it atomic ops behave as plain loads/stores.
module pu_or1k_ctrl_lsu_responder #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic                            ctrl_op_lsu_store_i,
  input  logic                            ctrl_op_lsu_atomic_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_lsu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_o,
  output logic                            lsu_valid_o,
  output logic                            lsu_except_dbus_o,
  output logic                            lsu_except_align_o,
  output logic                            atomic_flag_set_o,
  output logic                            atomic_flag_clear_o,
  output logic                            msync_stall_o,
  output logic                            dbus_req_o,
  output logic                            dbus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
  output logic [3:0]                      dbus_bsel_o,
  input  logic                            dbus_ack_i,
  input  logic                            dbus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, EXCEPT} state_t;
  state_t state_q, state_d;

  logic        lsu_req, misalign, start, issue, swa_fail;
  logic        bus_done, aborting;
  logic        ld_q, zext_q, abort_q;
  logic [1:0]  len_q;
  logic [3:0]  st_bsel;
  logic [31:0] st_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign lsu_req  = ctrl_op_lsu_load_i | ctrl_op_lsu_store_i;
  assign start    = (state_q == IDLE) & lsu_req & ~pipeline_flush_i;
  assign issue    = start & ~misalign & ~swa_fail;
  assign bus_done = dbus_ack_i | dbus_err_i;
  // A flush in the same cycle as the ack still counts as an abort.
  assign aborting = abort_q | pipeline_flush_i;

  assign lsu_valid_o   = (state_q == DONE);
  assign msync_stall_o = (state_q == ACCESS);

  always_comb begin
    misalign = 1'b0;
    case (ctrl_lsu_length_i)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ctrl_lsu_adr_i[0];
      default: misalign = (ctrl_lsu_adr_i[1:0] != 2'b00);
    endcase
  end

  // Big-endian lane steering for the bus write data.
  always_comb begin
    st_bsel = 4'b1111;
    st_dat  = ctrl_rfb_i;
    case (ctrl_lsu_length_i)
      2'b00: begin
        st_bsel = 4'b1000 >> ctrl_lsu_adr_i[1:0];
        st_dat  = {4{ctrl_rfb_i[7:0]}};
      end
      2'b01: begin
        st_bsel = ctrl_lsu_adr_i[1] ? 4'b0011 : 4'b1100;
        st_dat  = {2{ctrl_rfb_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the address held on the bus.
  always_comb begin
    ld_byte = dbus_dat_i[31:24];
    case (dbus_adr_o[1:0])
      2'b00: ld_byte = dbus_dat_i[31:24];
      2'b01: ld_byte = dbus_dat_i[23:16];
      2'b10: ld_byte = dbus_dat_i[15:8];
      2'b11: ld_byte = dbus_dat_i[7:0];
      default: ;
    endcase
    ld_half = dbus_adr_o[1] ? dbus_dat_i[15:0] : dbus_dat_i[31:16];
    ld_ext  = dbus_dat_i;
    case (len_q)
      2'b00:   ld_ext = zext_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = zext_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (start) begin
          if (misalign)      state_d = EXCEPT;
          else if (swa_fail) state_d = DONE;
          else               state_d = ACCESS;
        end
      ACCESS:
        if (bus_done) begin
          if (aborting)        state_d = IDLE;
          else if (dbus_err_i) state_d = EXCEPT;
          else                 state_d = DONE;
        end
      DONE:
        if (padv_ctrl_i | pipeline_flush_i) state_d = IDLE;
      EXCEPT:
        if (pipeline_flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req_o         <= 1'b0;
      dbus_we_o          <= 1'b0;
      dbus_adr_o         <= '0;
      dbus_dat_o         <= '0;
      dbus_bsel_o        <= '0;
      ld_q               <= 1'b0;
      len_q              <= 2'b00;
      zext_q             <= 1'b0;
      abort_q            <= 1'b0;
      lsu_result_o       <= '0;
      lsu_except_dbus_o  <= 1'b0;
      lsu_except_align_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start & misalign) lsu_except_align_o <= 1'b1;
          if (issue) begin
            dbus_req_o  <= 1'b1;
            dbus_we_o   <= ctrl_op_lsu_store_i;
            dbus_adr_o  <= ctrl_lsu_adr_i;
            dbus_dat_o  <= st_dat;
            dbus_bsel_o <= st_bsel;
            ld_q        <= ctrl_op_lsu_load_i;
            len_q       <= ctrl_lsu_length_i;
            zext_q      <= ctrl_lsu_zext_i;
            abort_q     <= 1'b0;
          end
        end
        ACCESS: begin
          // The bus cycle is never cut short; remember the flush instead.
          if (pipeline_flush_i) abort_q <= 1'b1;
          if (bus_done) begin
            dbus_req_o <= 1'b0;
            abort_q    <= 1'b0;
            if (!aborting) begin
              if (dbus_err_i) lsu_except_dbus_o <= 1'b1;
              else if (ld_q)  lsu_result_o      <= ld_ext;
            end
          end
        end
        EXCEPT:
          if (pipeline_flush_i) begin
            lsu_except_dbus_o  <= 1'b0;
            lsu_except_align_o <= 1'b0;
          end
        default: ;
      endcase
    end
  end

`ifdef PU_OR1K_LSU_ATOMIC_EN
  logic        resv_valid_q, lwa_q, swa_q, is_swa, resv_hit;
  logic [29:0] resv_adr_q;

  assign is_swa   = ctrl_op_lsu_store_i & ctrl_op_lsu_atomic_i;
  assign resv_hit = resv_valid_q & (resv_adr_q == ctrl_lsu_adr_i[31:2]);
  assign swa_fail = is_swa & ~resv_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid_q        <= 1'b0;
      resv_adr_q          <= '0;
      lwa_q               <= 1'b0;
      swa_q               <= 1'b0;
      atomic_flag_set_o   <= 1'b0;
      atomic_flag_clear_o <= 1'b0;
    end else begin
      atomic_flag_set_o   <= 1'b0;
      atomic_flag_clear_o <= 1'b0;
      if (start) begin
        // Every accepted swa consumes the reservation, hit or miss.
        if (is_swa) begin
          resv_valid_q <= 1'b0;
          if (!misalign && !resv_hit) atomic_flag_clear_o <= 1'b1;
        end else if (ctrl_op_lsu_store_i && !misalign &&
                     resv_adr_q == ctrl_lsu_adr_i[31:2]) begin
          resv_valid_q <= 1'b0;
        end
      end
      if (issue) begin
        lwa_q <= ctrl_op_lsu_load_i & ctrl_op_lsu_atomic_i;
        swa_q <= is_swa;
      end
      if (state_q == ACCESS && dbus_ack_i && !dbus_err_i && !aborting) begin
        if (lwa_q) begin
          resv_valid_q <= 1'b1;
          resv_adr_q   <= dbus_adr_o[31:2];
        end
        if (swa_q) atomic_flag_set_o <= 1'b1;
      end
    end
  end
`else
  logic unused_atomic;
  assign unused_atomic       = ctrl_op_lsu_atomic_i;
  assign swa_fail            = 1'b0;
  assign atomic_flag_set_o   = 1'b0;
  assign atomic_flag_clear_o = 1'b0;
`endif

endmodule

// File: tb/tb_pu_or1k_ctrl_lsu_responder.sv
// Testbench for pu_or1k_ctrl_lsu_responder: directed cases followed by
// randomized transactions, each checked against a transaction-level model.
module tb_pu_or1k_ctrl_lsu_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        padv_ctrl_i, pipeline_flush_i;
  logic        ctrl_op_lsu_load_i, ctrl_op_lsu_store_i, ctrl_op_lsu_atomic_i;
  logic [1:0]  ctrl_lsu_length_i;
  logic        ctrl_lsu_zext_i;
  logic [31:0] ctrl_lsu_adr_i, ctrl_rfb_i;
  logic [31:0] lsu_result_o;
  logic        lsu_valid_o, lsu_except_dbus_o, lsu_except_align_o;
  logic        atomic_flag_set_o, atomic_flag_clear_o, msync_stall_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_adr_o, dbus_dat_o;
  logic [3:0]  dbus_bsel_o;
  logic        dbus_ack_i, dbus_err_i;
  logic [31:0] dbus_dat_i;

  pu_or1k_ctrl_lsu_responder #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .padv_ctrl_i(padv_ctrl_i), .pipeline_flush_i(pipeline_flush_i),
    .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i), .ctrl_op_lsu_store_i(ctrl_op_lsu_store_i),
    .ctrl_op_lsu_atomic_i(ctrl_op_lsu_atomic_i), .ctrl_lsu_length_i(ctrl_lsu_length_i),
    .ctrl_lsu_zext_i(ctrl_lsu_zext_i), .ctrl_lsu_adr_i(ctrl_lsu_adr_i),
    .ctrl_rfb_i(ctrl_rfb_i), .lsu_result_o(lsu_result_o), .lsu_valid_o(lsu_valid_o),
    .lsu_except_dbus_o(lsu_except_dbus_o), .lsu_except_align_o(lsu_except_align_o),
    .atomic_flag_set_o(atomic_flag_set_o), .atomic_flag_clear_o(atomic_flag_clear_o),
    .msync_stall_o(msync_stall_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o), .dbus_bsel_o(dbus_bsel_o),
    .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .dbus_dat_i(dbus_dat_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_result = '0;
  bit          m_rv = 1'b0;
  logic [29:0] m_ra = '0;
`ifdef PU_OR1K_LSU_ATOMIC_EN
  bit atom_en = 1'b1;
`else
  bit atom_en = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_mis(input logic [1:0] len, input logic [31:0] a);
    if (len == 2'd1) return a[0];
    if (len == 2'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_bsel(input logic [1:0] len, input logic [31:0] a);
    if (len == 2'd0) return 4'(1 << (3 - int'(a[1:0])));
    if (len == 2'd1) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [1:0] len, input logic [31:0] d);
    if (len == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (len == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // Byte lane 0 is the most significant byte; shift it down, mask, extend.
  function automatic logic [31:0] m_load(input logic [1:0] len, input logic [31:0] a,
                                         input bit zx, input logic [31:0] rd);
    logic [31:0] v;
    if (len == 2'd0) begin
      v = (rd >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
      if (!zx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (len == 2'd1) begin
      v = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
      if (!zx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic run_op(input bit ld, input bit st, input bit at, input logic [1:0] len,
                        input bit zx, input logic [31:0] adr, input logic [31:0] rfb,
                        input logic [31:0] rdat, input int dly, input bit err, input bit fl);
    bit mis, swa, swa_ok;
    int c;
    mis    = is_mis(len, adr);
    swa    = atom_en && st && at;
    swa_ok = m_rv && (m_ra == adr[31:2]);
    ctrl_op_lsu_load_i   = ld;
    ctrl_op_lsu_store_i  = st;
    ctrl_op_lsu_atomic_i = at;
    ctrl_lsu_length_i    = len;
    ctrl_lsu_zext_i      = zx;
    ctrl_lsu_adr_i       = adr;
    ctrl_rfb_i           = rfb;
    step;
    ctrl_op_lsu_load_i   = 1'b0;
    ctrl_op_lsu_store_i  = 1'b0;
    ctrl_op_lsu_atomic_i = 1'b0;
    if (swa) m_rv = 1'b0;
    if (mis) begin
      chk("align_set", lsu_except_align_o, 1);
      chk("align_noreq", dbus_req_o, 0);
      chk("align_novalid", lsu_valid_o, 0);
      step; step;
      chk("align_hold", lsu_except_align_o, 1);
      chk("align_noreq2", dbus_req_o, 0);
      pipeline_flush_i = 1'b1; step; pipeline_flush_i = 1'b0;
      chk("align_clr", lsu_except_align_o, 0);
      return;
    end
    if (swa && !swa_ok) begin
      chk("swa_fail_valid", lsu_valid_o, 1);
      chk("swa_fail_clr", atomic_flag_clear_o, 1);
      chk("swa_fail_set", atomic_flag_set_o, 0);
      chk("swa_fail_noreq", dbus_req_o, 0);
      step;
      chk("swa_fail_pulse", atomic_flag_clear_o, 0);
      chk("swa_fail_hold", lsu_valid_o, 1);
      padv_ctrl_i = 1'b1; step; padv_ctrl_i = 1'b0;
      chk("swa_fail_retire", lsu_valid_o, 0);
      return;
    end
    if (st && !swa && m_rv && m_ra == adr[31:2]) m_rv = 1'b0;
    chk("req", dbus_req_o, 1);
    chk("we", dbus_we_o, st);
    chk("adr", dbus_adr_o, adr);
    chk("stall", msync_stall_o, 1);
    if (st) begin
      chk("bsel", dbus_bsel_o, m_bsel(len, adr));
      chk("wdat", dbus_dat_o, m_wdat(len, rfb));
    end
    c = 1;
    if (fl) begin
      pipeline_flush_i = 1'b1; step; pipeline_flush_i = 1'b0;
      c++;
    end
    while (c < dly) begin
      chk("req_hold", dbus_req_o, 1);
      step;
      c++;
    end
    chk("adr_hold", dbus_adr_o, adr);
    dbus_ack_i = ~err;
    dbus_err_i = err;
    dbus_dat_i = rdat;
    step;
    dbus_ack_i = 1'b0;
    dbus_err_i = 1'b0;
    dbus_dat_i = $urandom;
    chk("req_drop", dbus_req_o, 0);
    chk("stall_drop", msync_stall_o, 0);
    if (fl) begin
      chk("abort_novalid", lsu_valid_o, 0);
      chk("abort_nodbus", lsu_except_dbus_o, 0);
      chk("abort_noflag", atomic_flag_set_o, 0);
      step;
      chk("abort_idle", lsu_valid_o | msync_stall_o | dbus_req_o, 0);
    end else if (err) begin
      chk("dbus_set", lsu_except_dbus_o, 1);
      chk("dbus_novalid", lsu_valid_o, 0);
      step;
      chk("dbus_hold", lsu_except_dbus_o, 1);
      pipeline_flush_i = 1'b1; step; pipeline_flush_i = 1'b0;
      chk("dbus_clr", lsu_except_dbus_o, 0);
    end else begin
      if (ld) m_result = m_load(len, adr, zx, rdat);
      if (atom_en && ld && at) begin
        m_rv = 1'b1;
        m_ra = adr[31:2];
      end
      chk("valid", lsu_valid_o, 1);
      chk("result", lsu_result_o, m_result);
      chk("flag_set", atomic_flag_set_o, swa);
      chk("flag_clr", atomic_flag_clear_o, 0);
      step;
      chk("valid_hold", lsu_valid_o, 1);
      chk("flag_set_pulse", atomic_flag_set_o, 0);
      padv_ctrl_i = 1'b1; step; padv_ctrl_i = 1'b0;
      chk("valid_retire", lsu_valid_o, 0);
      chk("result_keep", lsu_result_o, m_result);
    end
  endtask

  initial begin
    rst = 1'b1;
    padv_ctrl_i = 1'b0; pipeline_flush_i = 1'b0;
    ctrl_op_lsu_load_i = 1'b0; ctrl_op_lsu_store_i = 1'b0; ctrl_op_lsu_atomic_i = 1'b0;
    ctrl_lsu_length_i = 2'd0; ctrl_lsu_zext_i = 1'b0;
    ctrl_lsu_adr_i = '0; ctrl_rfb_i = '0;
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_dat_i = '0;
    step; step;
    chk("rst_outs", {lsu_valid_o, lsu_except_dbus_o, lsu_except_align_o, atomic_flag_set_o,
                     atomic_flag_clear_o, msync_stall_o, dbus_req_o, dbus_we_o}, 0);
    chk("rst_result", lsu_result_o, 0);
    chk("rst_adr", dbus_adr_o, 0);
    rst = 1'b0;
    step;

    // directed
    run_op(1, 0, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0);
    run_op(1, 0, 0, 2'd0, 0, 32'h103, 0, 32'h000000F0, 1, 0, 0);
    run_op(1, 0, 0, 2'd0, 1, 32'h103, 0, 32'h000000F0, 3, 0, 0);
    run_op(0, 1, 0, 2'd1, 0, 32'h102, 32'h1234ABCD, 0, 2, 0, 0);
    run_op(1, 0, 0, 2'd2, 0, 32'h101, 0, 0, 1, 0, 0);
    run_op(0, 1, 0, 2'd2, 0, 32'h104, 32'h55AA55AA, 0, 2, 1, 0);
    run_op(0, 1, 0, 2'd2, 0, 32'h108, 32'h0BADF00D, 0, 4, 0, 1);
    run_op(1, 0, 1, 2'd2, 0, 32'h200, 0, 32'hCAFEF00D, 2, 0, 0);
    run_op(0, 1, 1, 2'd2, 0, 32'h200, 32'h11112222, 0, 2, 0, 0);
    run_op(0, 1, 1, 2'd2, 0, 32'h200, 32'h33334444, 0, 2, 0, 0);

    // a request under flush in IDLE must not start
    ctrl_op_lsu_load_i = 1'b1; ctrl_lsu_length_i = 2'd2; ctrl_lsu_adr_i = 32'h300;
    pipeline_flush_i = 1'b1;
    step;
    ctrl_op_lsu_load_i = 1'b0; pipeline_flush_i = 1'b0;
    chk("flush_idle_noreq", dbus_req_o, 0);
    chk("flush_idle_nostall", msync_stall_o, 0);
    step;

    // randomized
    for (int n = 0; n < 300; n++) begin
      bit ld, at, zx, er, fl;
      logic [1:0] len;
      logic [31:0] a;
      int dly;
      ld  = $urandom_range(0, 1);
      at  = ($urandom_range(0, 2) == 0);
      zx  = $urandom_range(0, 1);
      len = 2'($urandom_range(0, 2));
      a   = 32'h200 + $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
        if (len == 2'd1) a[0] = 1'b0;
        if (len == 2'd2) a[1:0] = 2'b00;
      end
      if (at) begin
        len = 2'd2;
        if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      end
      er  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(1, 4);
      if (fl && dly < 2) dly = 2;
      run_op(ld, !ld, at, len, zx, a, $urandom, $urandom, dly, er, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
